// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one combinational RV32 ALU between two requesters.
// Flow per operation: request handshake, one execute cycle, then a held response.
module alu_arbiter #(
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 10
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [DW-1:0] req0_imm,
  input  logic          req0_imm_en,
  input  logic [CW-1:0] req0_ctrl,

  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [DW-1:0] req1_imm,
  input  logic          req1_imm_en,
  input  logic [CW-1:0] req1_ctrl,

  output logic          rsp0_valid,
  input  logic          rsp0_ready,
  output logic [DW-1:0] rsp0_data,
  output logic          rsp0_n,
  output logic          rsp0_z,

  output logic          rsp1_valid,
  input  logic          rsp1_ready,
  output logic [DW-1:0] rsp1_data,
  output logic          rsp1_n,
  output logic          rsp1_z,

  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [DW-1:0] alu_imm,
  output logic          alu_imm_en,
  output logic [CW-1:0] alu_ctrl,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_n,
  input  logic          alu_z,

  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e        state_q;
  logic [DW-1:0] a_q, b_q, imm_q, res_q;
  logic          imm_en_q, n_q, z_q;
  logic [CW-1:0] ctrl_q;
  logic          owner_q;
  logic          ptr_q;
  logic [1:0]    rsp_valid_q;
  logic          busy_q;

  logic          gnt0_c, gnt1_c;
  logic          rsp_hs_c;
  logic [DW-1:0] sel_a_c, sel_b_c, sel_imm_c;
  logic          sel_imm_en_c;
  logic [CW-1:0] sel_ctrl_c;

  // Grant only in IDLE; on contention the pointer picks the requester.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && (!req1_valid || !ptr_q)) begin
        gnt0_c = 1'b1;
      end else if (req1_valid) begin
        gnt1_c = 1'b1;
      end
    end
  end

  // Ready is masked while reset is asserted so nothing is accepted from a dead block.
  assign req0_ready = rst_n & gnt0_c;
  assign req1_ready = rst_n & gnt1_c;

  always_comb begin
    sel_a_c      = req0_a;
    sel_b_c      = req0_b;
    sel_imm_c    = req0_imm;
    sel_imm_en_c = req0_imm_en;
    sel_ctrl_c   = req0_ctrl;
    if (gnt1_c) begin
      sel_a_c      = req1_a;
      sel_b_c      = req1_b;
      sel_imm_c    = req1_imm;
      sel_imm_en_c = req1_imm_en;
      sel_ctrl_c   = req1_ctrl;
    end
  end

  assign rsp_hs_c = owner_q ? (rsp_valid_q[1] & rsp1_ready)
                            : (rsp_valid_q[0] & rsp0_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      imm_q       <= '0;
      imm_en_q    <= 1'b0;
      ctrl_q      <= '0;
      res_q       <= '0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      owner_q     <= 1'b0;
      ptr_q       <= 1'b0;
      rsp_valid_q <= 2'b00;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt0_c || gnt1_c) begin
            a_q      <= sel_a_c;
            b_q      <= sel_b_c;
            imm_q    <= sel_imm_c;
            imm_en_q <= sel_imm_en_c;
            ctrl_q   <= sel_ctrl_c;
            owner_q  <= gnt1_c;
            busy_q   <= 1'b1;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          res_q                <= alu_out;
          n_q                  <= alu_n;
          z_q                  <= alu_z;
          rsp_valid_q[owner_q] <= 1'b1;
          state_q              <= RESP;
        end
        RESP: begin
          // Hold here under backpressure; the pointer moves to the loser on completion.
          if (rsp_hs_c) begin
            rsp_valid_q <= 2'b00;
            ptr_q       <= ~owner_q;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 2'b00;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_imm    = imm_q;
  assign alu_imm_en = imm_en_q;
  assign alu_ctrl   = ctrl_q;

  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_data  = res_q;
  assign rsp1_data  = res_q;
  assign rsp0_n     = n_q;
  assign rsp1_n     = n_q;
  assign rsp0_z     = z_q;
  assign rsp1_z     = z_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic, checked against
// a transaction-level model of arbitration, latency and ALU results.
module tb_alu_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 10;
  localparam logic [CW-1:0] C_ADD = 10'b0000000000;
  localparam logic [CW-1:0] C_SUB = 10'b0100000000;
  localparam logic [CW-1:0] C_SRA = 10'b0100000101;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_ready, req0_imm_en;
  logic [DW-1:0] req0_a, req0_b, req0_imm;
  logic [CW-1:0] req0_ctrl;
  logic          req1_valid, req1_ready, req1_imm_en;
  logic [DW-1:0] req1_a, req1_b, req1_imm;
  logic [CW-1:0] req1_ctrl;
  logic          rsp0_valid, rsp0_ready, rsp0_n, rsp0_z;
  logic [DW-1:0] rsp0_data;
  logic          rsp1_valid, rsp1_ready, rsp1_n, rsp1_z;
  logic [DW-1:0] rsp1_data;
  logic [DW-1:0] alu_a, alu_b, alu_imm, alu_out;
  logic          alu_imm_en, alu_n, alu_z;
  logic [CW-1:0] alu_ctrl;
  logic          busy;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_imm(req0_imm), .req0_imm_en(req0_imm_en), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_imm(req1_imm), .req1_imm_en(req1_imm_en), .req1_ctrl(req1_ctrl),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp0_n(rsp0_n), .rsp0_z(rsp0_z),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .rsp1_n(rsp1_n), .rsp1_z(rsp1_z),
    .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm), .alu_imm_en(alu_imm_en),
    .alu_ctrl(alu_ctrl), .alu_out(alu_out), .alu_n(alu_n), .alu_z(alu_z),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // RV32 ALU behaviour; ctrl = {funct7, funct3}
  function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] imm, input logic ie,
                                           input logic [CW-1:0] c);
    logic [DW-1:0] op2;
    op2 = ie ? imm : b;
    case (c[2:0])
      3'd0: return c[8] ? a - op2 : a + op2;
      3'd1: return a << op2[4:0];
      3'd2: return ($signed(a) < $signed(op2)) ? DW'(1) : DW'(0);
      3'd3: return (a < op2) ? DW'(1) : DW'(0);
      3'd4: return a ^ op2;
      3'd5: return c[8] ? DW'($signed(a) >>> op2[4:0]) : a >> op2[4:0];
      3'd6: return a | op2;
      default: return a & op2;
    endcase
  endfunction

  assign alu_out = alu_fn(alu_a, alu_b, alu_imm, alu_imm_en, alu_ctrl);
  assign alu_n   = alu_out[DW-1];
  assign alu_z   = (alu_out == '0);

  // Transaction-level reference: one op outstanding, response two cycles after grant.
  logic          m_pend, m_fav, m_owner, m_resp, g0, g1;
  int            m_age;
  logic [33:0]   m_exp, m_last, e_cur;
  logic [106:0]  m_ops;
  logic [DW-1:0] m_res;
  int            grants[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      m_pend = 1'b0;
      m_fav  = 1'b0;
      m_age  = 0;
      m_last = '0;
      check("reset_outputs", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy,
                              rsp0_data, rsp1_data}, '0);
    end else begin
      if (m_pend) m_age++;
      m_resp = m_pend && (m_age >= 2);
      e_cur  = m_resp ? m_exp : m_last;
      check("rsp_valid", {rsp1_valid, rsp0_valid}, {m_resp && m_owner, m_resp && !m_owner});
      check("rsp0_result", {rsp0_n, rsp0_z, rsp0_data}, e_cur);
      check("rsp1_result", {rsp1_n, rsp1_z, rsp1_data}, e_cur);
      g0 = !m_pend && req0_valid && (!req1_valid || !m_fav);
      g1 = !m_pend && req1_valid && (!req0_valid || m_fav);
      check("req_ready", {req1_ready, req0_ready}, {g1, g0});
      check("busy", busy, m_pend);
      if (m_pend)
        check("alu_operands", {alu_ctrl, alu_imm_en, alu_imm, alu_b, alu_a}, m_ops);
      if (m_resp && (m_owner ? rsp1_ready : rsp0_ready)) begin
        m_pend = 1'b0;
        m_fav  = !m_owner;
        m_last = m_exp;
      end else if (g0 || g1) begin
        m_owner = g1;
        if (g1) begin
          m_ops = {req1_ctrl, req1_imm_en, req1_imm, req1_b, req1_a};
          m_res = alu_fn(req1_a, req1_b, req1_imm, req1_imm_en, req1_ctrl);
        end else begin
          m_ops = {req0_ctrl, req0_imm_en, req0_imm, req0_b, req0_a};
          m_res = alu_fn(req0_a, req0_b, req0_imm, req0_imm_en, req0_ctrl);
        end
        m_exp  = {m_res[DW-1], m_res == '0, m_res};
        m_pend = 1'b1;
        m_age  = 0;
        grants.push_back(g1 ? 1 : 0);
      end
    end
  end

  task automatic set_req(input int k, input logic v, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [DW-1:0] imm,
                         input logic ie, input logic [CW-1:0] c);
    if (k == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_imm = imm; req0_imm_en = ie; req0_ctrl = c;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_imm = imm; req1_imm_en = ie; req1_ctrl = c;
    end
  endtask

  task automatic set_valid(input int k, input logic v);
    if (k == 0) req0_valid = v;
    else        req1_valid = v;
  endtask

  task automatic rand_payload(input int k);
    logic [DW-1:0] a, b, imm;
    logic          ie, f7b5;
    logic [2:0]    f3;
    a    = $urandom;
    b    = $urandom;
    imm  = $urandom;
    ie   = 1'($urandom_range(0, 1));
    f7b5 = 1'($urandom_range(0, 1));
    f3   = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 7) == 0) begin
      b   = a;
      imm = a;
    end
    set_req(k, 1'b1, a, b, imm, ie, {1'b0, f7b5, 5'b00000, f3});
  endtask

  task automatic step_req(input int k, input logic acc);
    logic v;
    v = (k == 0) ? req0_valid : req1_valid;
    if (acc) begin
      if ($urandom_range(0, 1) == 0) rand_payload(k);
      else                           set_valid(k, 1'b0);
    end else if (v) begin
      if ($urandom_range(0, 15) == 0) set_valid(k, 1'b0);
    end else if ($urandom_range(0, 1) == 0) begin
      rand_payload(k);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic          acc0, acc1;
  logic [DW-1:0] held;
  bit            done4;

  initial begin
    rst_n = 1'b0;
    set_req(0, 1'b0, '0, '0, '0, 1'b0, '0);
    set_req(1, 1'b0, '0, '0, '0, 1'b0, '0);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    do_reset();

    // Single ADD from req0
    tick();
    set_req(0, 1'b1, 5, 7, 0, 1'b0, C_ADD);
    #1 check("t1_ready", {req1_ready, req0_ready}, 2'b01);
    tick();
    set_valid(0, 1'b0);
    check("t1_exec_no_rsp", {rsp1_valid, rsp0_valid, busy}, 3'b001);
    tick();
    check("t1_rsp", {rsp1_valid, rsp0_valid, rsp0_n, rsp0_z, rsp0_data}, {4'b0100, 32'd12});
    tick();
    check("t1_idle", {busy, rsp1_valid, rsp0_valid}, 3'b000);

    // Simultaneous requests after reset: req0 wins, then req1
    do_reset();
    set_req(0, 1'b1, 3, 3, 0, 1'b0, C_SUB);
    set_req(1, 1'b1, 1, 1, 0, 1'b0, C_ADD);
    #1 check("t2_grant0", {req1_ready, req0_ready}, 2'b01);
    tick();
    set_valid(0, 1'b0);
    check("t2_exec_ready", req1_ready, 1'b0);
    tick();
    check("t2_rsp0", {rsp1_valid, rsp0_valid, rsp0_n, rsp0_z, rsp0_data}, {4'b0101, 32'd0});
    check("t2_resp_ready", req1_ready, 1'b0);
    tick();
    check("t2_grant1", {req1_ready, req0_ready}, 2'b10);
    tick();
    set_valid(1, 1'b0);
    tick();
    check("t2_rsp1", {rsp1_valid, rsp0_valid, rsp1_n, rsp1_z, rsp1_data}, {4'b1000, 32'd2});
    tick();

    // Continuous contention alternates grants
    grants.delete();
    set_req(0, 1'b1, 10, 20, 0, 1'b0, C_ADD);
    set_req(1, 1'b1, 50, 8, 0, 1'b0, C_SUB);
    done4 = 1'b0;
    for (int i = 0; i < 40 && !done4; i++) begin
      tick();
      if (grants.size() >= 4) done4 = 1'b1;
    end
    set_valid(0, 1'b0);
    set_valid(1, 1'b0);
    check("t3_grant_count", 32'(grants.size()), 32'd4);
    if (grants.size() >= 4)
      check("t3_grant_order", {grants[0][1:0], grants[1][1:0], grants[2][1:0], grants[3][1:0]},
            8'b00_01_00_01);
    repeat (4) tick();

    // SRA with immediate
    set_req(1, 1'b1, 32'h8000_0000, $urandom, 4, 1'b1, C_SRA);
    #1 check("t4_ready", req1_ready, 1'b1);
    tick();
    set_valid(1, 1'b0);
    tick();
    check("t4_sra", {rsp1_valid, rsp1_n, rsp1_z, rsp1_data}, {3'b110, 32'hF800_0000});
    tick();

    // Backpressure on rsp0 while req1 waits
    rsp0_ready = 1'b0;
    set_req(0, 1'b1, 100, 23, 0, 1'b0, C_ADD);
    tick();
    set_valid(0, 1'b0);
    set_req(1, 1'b1, 9, 9, 0, 1'b0, C_ADD);
    tick();
    held = rsp0_data;
    for (int i = 0; i < 4; i++) begin
      check("t5_stall", {rsp0_valid, req1_ready, busy, rsp0_data}, {3'b101, held});
      check("t5_stall_data", rsp0_data, 32'd123);
      tick();
    end
    rsp0_ready = 1'b1;
    tick();
    check("t5_grant1", req1_ready, 1'b1);
    tick();
    set_valid(1, 1'b0);
    tick();
    check("t5_rsp1", {rsp1_valid, rsp1_data}, {1'b1, 32'd18});
    tick();

    // Reset during EXEC discards the in-flight op
    set_req(0, 1'b1, 7, 8, 0, 1'b0, C_ADD);
    tick();
    set_valid(0, 1'b0);
    rst_n = 1'b0;
    #1 check("t6_abort", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, rsp0_data},
             '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_no_stale", {rsp1_valid, rsp0_valid}, 2'b00);
    end
    set_req(1, 1'b1, 2, 3, 0, 1'b0, C_ADD);
    tick();
    set_valid(1, 1'b0);
    tick();
    check("t6_new_op", {rsp1_valid, rsp1_data}, {1'b1, 32'd5});
    tick();

    // Randomized traffic with backpressure and occasional reset
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      acc0 = req0_valid & req0_ready;
      acc1 = req1_valid & req1_ready;
      tick();
      if ($urandom_range(0, 999) == 0) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        step_req(0, acc0);
        step_req(1, acc1);
        rsp0_ready = ($urandom_range(0, 3) != 0);
        rsp1_ready = ($urandom_range(0, 3) != 0);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    repeat (6) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
